// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment display slice: character codes,
// segment bit positions and the glyph table used by seg14_font.
// Segment order in a glyph word, MSB first: a,b,c,d,e,f,g1,g2,h,i,j,k,l,m
// (h,i,j = upper diagonal/centre/diagonal, k,l,m = lower diagonal/centre/diagonal).
package seg14_pkg;

    // Character codes
    localparam logic [5:0] CHR_SPACE = 6'd0;
    localparam logic [5:0] CHR_A     = 6'd1;
    localparam logic [5:0] CHR_0     = 6'd27;

    // Segment bit positions inside a 14-bit glyph
    localparam int SEG_A  = 13;
    localparam int SEG_B  = 12;
    localparam int SEG_C  = 11;
    localparam int SEG_D  = 10;
    localparam int SEG_E  = 9;
    localparam int SEG_F  = 8;
    localparam int SEG_G1 = 7;
    localparam int SEG_G2 = 6;
    localparam int SEG_H  = 5;
    localparam int SEG_I  = 4;
    localparam int SEG_J  = 3;
    localparam int SEG_K  = 2;
    localparam int SEG_L  = 1;
    localparam int SEG_M  = 0;

    // Glyphs                                  abcdef g1g2 hijklm
    localparam logic [13:0] GLYPH_SPACE = 14'b00000000000000;
    localparam logic [13:0] GLYPH_A     = 14'b11101111000000;
    localparam logic [13:0] GLYPH_B     = 14'b11110001010010;
    localparam logic [13:0] GLYPH_C     = 14'b10011100000000;
    localparam logic [13:0] GLYPH_D     = 14'b11110000010010;
    localparam logic [13:0] GLYPH_E     = 14'b10011110000000;
    localparam logic [13:0] GLYPH_F     = 14'b10001110000000;
    localparam logic [13:0] GLYPH_G     = 14'b10111101000000;
    localparam logic [13:0] GLYPH_H     = 14'b01101111000000;
    localparam logic [13:0] GLYPH_I     = 14'b10010000010010;
    localparam logic [13:0] GLYPH_J     = 14'b01111000000000;
    localparam logic [13:0] GLYPH_K     = 14'b00001110001001;
    localparam logic [13:0] GLYPH_L     = 14'b00011100000000;
    localparam logic [13:0] GLYPH_M     = 14'b01101100101000;
    localparam logic [13:0] GLYPH_N     = 14'b01101100100001;
    localparam logic [13:0] GLYPH_O     = 14'b11111100000000;
    localparam logic [13:0] GLYPH_P     = 14'b11001111000000;
    localparam logic [13:0] GLYPH_Q     = 14'b11111100000001;
    localparam logic [13:0] GLYPH_R     = 14'b11001111000001;
    localparam logic [13:0] GLYPH_S     = 14'b10110111000000;
    localparam logic [13:0] GLYPH_T     = 14'b10000000010010;
    localparam logic [13:0] GLYPH_U     = 14'b01111100000000;
    localparam logic [13:0] GLYPH_V     = 14'b00001100001100;
    localparam logic [13:0] GLYPH_W     = 14'b01101100000101;
    localparam logic [13:0] GLYPH_X     = 14'b00000000101101;
    localparam logic [13:0] GLYPH_Y     = 14'b00000000101010;
    localparam logic [13:0] GLYPH_Z     = 14'b10010000001100;
    localparam logic [13:0] GLYPH_0     = 14'b11111100001100;
    localparam logic [13:0] GLYPH_1     = 14'b01100000001000;
    localparam logic [13:0] GLYPH_2     = 14'b11011011000000;
    localparam logic [13:0] GLYPH_3     = 14'b11110001000000;
    localparam logic [13:0] GLYPH_4     = 14'b01100111000000;
    localparam logic [13:0] GLYPH_5     = 14'b10110111000000;
    localparam logic [13:0] GLYPH_6     = 14'b10111111000000;
    localparam logic [13:0] GLYPH_7     = 14'b11100000000000;
    localparam logic [13:0] GLYPH_8     = 14'b11111111000000;
    localparam logic [13:0] GLYPH_9     = 14'b11110111000000;

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to 14-segment glyph lookup.
// Codes 37..63 are unassigned and render blank.
module seg14_font
    import seg14_pkg::*;
(
    input  logic [5:0]  code,
    output logic [13:0] glyph
);

    // Glyph table lookup
    always_comb begin
        glyph = GLYPH_SPACE;
        case (code)
            CHR_SPACE: glyph = GLYPH_SPACE;
            CHR_A:     glyph = GLYPH_A;
            6'd2:      glyph = GLYPH_B;
            6'd3:      glyph = GLYPH_C;
            6'd4:      glyph = GLYPH_D;
            6'd5:      glyph = GLYPH_E;
            6'd6:      glyph = GLYPH_F;
            6'd7:      glyph = GLYPH_G;
            6'd8:      glyph = GLYPH_H;
            6'd9:      glyph = GLYPH_I;
            6'd10:     glyph = GLYPH_J;
            6'd11:     glyph = GLYPH_K;
            6'd12:     glyph = GLYPH_L;
            6'd13:     glyph = GLYPH_M;
            6'd14:     glyph = GLYPH_N;
            6'd15:     glyph = GLYPH_O;
            6'd16:     glyph = GLYPH_P;
            6'd17:     glyph = GLYPH_Q;
            6'd18:     glyph = GLYPH_R;
            6'd19:     glyph = GLYPH_S;
            6'd20:     glyph = GLYPH_T;
            6'd21:     glyph = GLYPH_U;
            6'd22:     glyph = GLYPH_V;
            6'd23:     glyph = GLYPH_W;
            6'd24:     glyph = GLYPH_X;
            6'd25:     glyph = GLYPH_Y;
            6'd26:     glyph = GLYPH_Z;
            CHR_0:     glyph = GLYPH_0;
            6'd28:     glyph = GLYPH_1;
            6'd29:     glyph = GLYPH_2;
            6'd30:     glyph = GLYPH_3;
            6'd31:     glyph = GLYPH_4;
            6'd32:     glyph = GLYPH_5;
            6'd33:     glyph = GLYPH_6;
            6'd34:     glyph = GLYPH_7;
            6'd35:     glyph = GLYPH_8;
            6'd36:     glyph = GLYPH_9;
            default:   glyph = GLYPH_SPACE;
        endcase
    end

endmodule

// File: rtl/seg14_scroll_mux.sv
// Multiplexed 14-segment display driver with a writable message buffer and
// horizontal scrolling. One digit is driven per scan slot; the character for
// digit d is buf[(offset + d) mod MSG_LEN]. The offset only changes at a frame
// boundary, so a frame never mixes two offsets.
// Optional feature macro: SEG14_BLINK_EN (adds the blink input and phase bit).
module seg14_scroll_mux
    import seg14_pkg::*;
#(
    parameter int DIGITS        = 12,
    parameter int MSG_LEN       = 32,
    parameter int SCAN_DIV      = 1,
    parameter int SCROLL_FRAMES = 64
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [5:0]                 wr_char,
    input  logic                       scroll_en,
    input  logic                       home,
`ifdef SEG14_BLINK_EN
    input  logic                       blink,
`endif
    output logic [DIGITS-1:0]          sel,
    output logic [13:0]                segm,
    output logic                       frame_start
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int DW = $clog2(DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [5:0]        msg_mem [MSG_LEN];
    logic [DW-1:0]     d_reg;
    logic [PW-1:0]     presc_reg;
    logic [AW-1:0]     offset_reg;
    logic [FW-1:0]     frame_reg;
    logic [DIGITS-1:0] sel_reg, sel_next;
    logic [13:0]       segm_reg, segm_next;
    logic              frame_start_reg;
    logic              slot_end, frame_end, frame_wrap;
    logic [AW:0]       rd_sum;
    logic [AW-1:0]     rd_addr;
    logic [5:0]        rd_char;
    logic [13:0]       glyph;
    logic              blank;

    assign slot_end   = (presc_reg == PW'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (d_reg == DW'(DIGITS - 1));
    assign frame_wrap = frame_end && (frame_reg == FW'(SCROLL_FRAMES - 1));

    // Message buffer: cleared by reset, out-of-range addresses dropped.
    // The read below is combinational, so a same-cycle write shows next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_mem[i] <= CHR_SPACE;
            end
        end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) begin
            msg_mem[wr_addr] <= wr_char;
        end
    end

    // Buffer index for the current digit; offset + d < 2*MSG_LEN, so one
    // conditional subtract is enough to wrap it.
    always_comb begin
        rd_sum  = {1'b0, offset_reg} + (AW+1)'(d_reg);
        rd_addr = rd_sum[AW-1:0];
        if (rd_sum >= (AW+1)'(MSG_LEN)) begin
            rd_addr = AW'(rd_sum - (AW+1)'(MSG_LEN));
        end
    end

    assign rd_char = msg_mem[rd_addr];

    seg14_font u_font (
        .code  (rd_char),
        .glyph (glyph)
    );

    // One-hot select decode of the scan index
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign sel_next[gi] = (d_reg == DW'(gi));
    end

`ifdef SEG14_BLINK_EN
    logic phase_reg;

    // Blink phase flips each time the frame counter wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= 1'b0;
        end else if (!home && frame_wrap) begin
            phase_reg <= ~phase_reg;
        end
    end

    assign blank = blink & phase_reg;
`else
    assign blank = 1'b0;
`endif

    // Segment pattern for the digit being driven
    always_comb begin
        segm_next = blank ? 14'd0 : glyph;
    end

    // Scan prescaler, digit index, frame counter and scroll offset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg  <= '0;
            d_reg      <= '0;
            frame_reg  <= '0;
            offset_reg <= '0;
        end else begin
            if (slot_end) begin
                presc_reg <= '0;
                d_reg     <= (d_reg == DW'(DIGITS - 1)) ? '0 : d_reg + DW'(1);
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            if (home) begin
                offset_reg <= '0;
                frame_reg  <= '0;
            end else if (frame_wrap) begin
                frame_reg <= '0;
                if (scroll_en) begin
                    offset_reg <= (offset_reg == AW'(MSG_LEN - 1)) ? '0 : offset_reg + AW'(1);
                end
            end else if (frame_end) begin
                frame_reg <= frame_reg + FW'(1);
            end
        end
    end

    // Registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg         <= '0;
            segm_reg        <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            sel_reg         <= sel_next;
            segm_reg        <= segm_next;
            frame_start_reg <= (d_reg == '0) && (presc_reg == '0);
        end
    end

    assign sel         = sel_reg;
    assign segm        = segm_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg14_scroll_mux.sv
// Directed bench for seg14_scroll_mux: one instance with one digit per clock
// and a 2-frame scroll period, one with SCAN_DIV=4 and a 20-entry buffer.
module tb_seg14_scroll_mux;

    localparam logic [13:0] G_SP = 14'b00000000000000;
    localparam logic [13:0] G_I  = 14'b10010000010010;
    localparam logic [13:0] G_A  = 14'b11101111000000;
    localparam logic [13:0] G_T  = 14'b10000000010010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [5:0]  wr_char = '0;
    logic        scroll_en = 1'b0;
    logic        home = 1'b0;
    logic        blink = 1'b0;
    logic [11:0] sel, sel4;
    logic [13:0] segm, segm4;
    logic        fs, fs4;

    int tests = 0;
    int fails = 0;

    // "ING ELEC ITA"
    logic [5:0] msg [12] = '{6'd9, 6'd14, 6'd7, 6'd0, 6'd5, 6'd12,
                             6'd5, 6'd3, 6'd0, 6'd9, 6'd20, 6'd1};

    always #5 clk = ~clk;

    seg14_scroll_mux #(.DIGITS(12), .MSG_LEN(32), .SCAN_DIV(1), .SCROLL_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .scroll_en(scroll_en), .home(home),
`ifdef SEG14_BLINK_EN
        .blink(blink),
`endif
        .sel(sel), .segm(segm), .frame_start(fs)
    );

    seg14_scroll_mux #(.DIGITS(12), .MSG_LEN(20), .SCAN_DIV(4), .SCROLL_FRAMES(2)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .scroll_en(1'b0), .home(home),
`ifdef SEG14_BLINK_EN
        .blink(blink),
`endif
        .sel(sel4), .segm(segm4), .frame_start(fs4)
    );

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(input bit use4);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            seen = use4 ? fs4 : fs;
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL wait_frame_start: observed no pulse expected pulse within 200 cycles");
        end
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_sel", 16'(sel), 16'h0000);
        check("rst_segm", 16'(segm), 16'h0000);
        check("rst_fs", 16'(fs), 16'h0000);
        check("rst_sel4", 16'(sel4), 16'h0000);

        // First edge after release: digit 0, frame_start, empty buffer
        rst = 1'b0;
        step();
        check("rel_sel", 16'(sel), 16'h0001);
        check("rel_fs", 16'(fs), 16'h0001);
        check("rel_segm", 16'(segm), 16'(G_SP));
        check("rel_sel4", 16'(sel4), 16'h0001);
        check("rel_fs4", 16'(fs4), 16'h0001);

        // Load the message
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_char = msg[i];
            step();
        end
        wr_en = 1'b0;

        // Static display, offset 0
        wait_fs(0);
        check("d0_sel", 16'(sel), 16'h0001);
        check("d0_segm_I", 16'(segm), 16'(G_I));
        step(3);
        check("d3_sel", 16'(sel), 16'h0008);
        check("d3_segm_sp", 16'(segm), 16'(G_SP));
        step(7);
        check("d10_segm_T", 16'(segm), 16'(G_T));
        step();
        check("d11_sel", 16'(sel), 16'h0800);
        check("d11_segm_A", 16'(segm), 16'(G_A));

        // SCAN_DIV=4: each select held 4 cycles, frame_start every 48 cycles
        wait_fs(1);
        for (int c = 0; c < 48; c++) begin
            check("div4_sel", 16'(sel4), 16'(12'h001 << (c / 4)));
            check("div4_fs", 16'(fs4), 16'(c == 0));
            step();
        end
        check("div4_fs_period", 16'(fs4), 16'h0001);

        // Scrolling: home mid-frame aligns the frame counter
        wait_fs(0);
        home = 1'b1;
        step();
        home = 1'b0;
        scroll_en = 1'b1;
        wait_fs(0);
        check("scrA_d0_I", 16'(segm), 16'(G_I));
        wait_fs(0);                       // offset 1
        step(2);
        check("scrB_d2_sp", 16'(segm), 16'(G_SP));
        step(6);
        check("scrB_d8_I", 16'(segm), 16'(G_I));
        step();
        check("scrB_d9_T", 16'(segm), 16'(G_T));
        step();
        check("scrB_d10_A", 16'(segm), 16'(G_A));
        for (int n = 0; n < 60; n++) wait_fs(0);  // offset 31
        check("off31_d0_sp", 16'(segm), 16'(G_SP));
        step();
        check("off31_d1_I", 16'(segm), 16'(G_I));
        step(10);
        check("off31_d11_T", 16'(segm), 16'(G_T));
        wait_fs(0);
        wait_fs(0);                       // offset wrapped to 0
        check("wrap_d0_I", 16'(segm), 16'(G_I));
        step(11);
        check("wrap_d11_A", 16'(segm), 16'(G_A));

        // home coincident with a scroll step keeps offset 0
        wait_fs(0);
        step(10);
        home = 1'b1;
        step();
        home = 1'b0;
        scroll_en = 1'b0;
        wait_fs(0);
        check("home_d0_I", 16'(segm), 16'(G_I));

        // Same-cycle write to the entry being read
        step(2);
        wr_en = 1'b1; wr_addr = 5'd3; wr_char = 6'd20;
        step();
        wr_en = 1'b0;
        check("wrsame_sel", 16'(sel), 16'h0008);
        check("wrsame_old", 16'(segm), 16'(G_SP));
        wait_fs(0);
        step(3);
        check("wrsame_new_T", 16'(segm), 16'(G_T));

        // Out-of-range writes on the 20-entry instance
        wr_en = 1'b1; wr_addr = 5'd20; wr_char = 6'd20;
        step();
        wr_addr = 5'd31;
        step();
        wr_en = 1'b0;
        wait_fs(1);
        check("oor_d0_I", 16'(segm4), 16'(G_I));
        step(12);
        check("oor_d3_T", 16'(segm4), 16'(G_T));
        step(32);
        check("oor_d11_A", 16'(segm4), 16'(G_A));

        // Reset mid-frame, with a write attempted during reset
        wait_fs(0);
        step(4);
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_char = 6'd20;
        step();
        check("mrst_sel", 16'(sel), 16'h0000);
        check("mrst_segm", 16'(segm), 16'h0000);
        check("mrst_fs", 16'(fs), 16'h0000);
        step();
        rst = 1'b0;
        wr_en = 1'b0;
        step();
        check("post_sel", 16'(sel), 16'h0001);
        check("post_fs", 16'(fs), 16'h0001);
        check("post_d0_sp", 16'(segm), 16'(G_SP));
        step(3);
        check("post_d3_sp", 16'(segm), 16'(G_SP));
        step(7);
        check("post_d10_sp", 16'(segm), 16'(G_SP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
